// File: rtl/fifo_drain_if.sv
// Stream-side bundle of the FIFO drain block: FIFO read port plus output stream.
interface fifo_drain_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  fifo_empty;
  logic                  fifo_underflow;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  // The drain block: reads the FIFO and sources the output stream.
  modport master (
    output fifo_rd_en,
    input  fifo_data_out,
    input  fifo_empty,
    input  fifo_underflow,
    output m_valid,
    input  m_ready,
    output m_data
  );

  // The surroundings: FIFO read port and downstream consumer.
  modport slave (
    input  fifo_rd_en,
    output fifo_data_out,
    output fifo_empty,
    output fifo_underflow,
    input  m_valid,
    output m_ready,
    input  m_data
  );
endinterface

// File: rtl/fifo_drain.sv
// Drains a burst of words from a one-cycle-latency FIFO into a valid/ready
// stream through a two-entry skid buffer.
module fifo_drain #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] burst_len,
  fifo_drain_if.master         bus,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_WIDTH-1:0] words_sent,
  output logic                 err_underflow
);

  localparam int unsigned SLOT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued_q;
  logic [LEN_WIDTH-1:0]  sent_q;
  logic                  inflight_q;
  logic [1:0]            occ_q;
  logic [DATA_WIDTH-1:0] buf0_q;
  logic [DATA_WIDTH-1:0] buf1_q;
  logic                  err_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  start_acc;
  logic                  pop;
  logic                  rd_en;
  logic [SLOT_W-1:0]     slots;

  // Next-state decode; start is only honoured from IDLE.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = (burst_len == '0) ? DONE : BURST;
        end
      end
      BURST: begin
        if (sent_q == len_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read issue: only when a buffer slot is guaranteed for the returning word.
  always_comb begin
    pop   = (occ_q != 2'd0) && bus.m_ready;
    slots = SLOT_W'(occ_q) + SLOT_W'(inflight_q) - SLOT_W'(pop);
    rd_en = rst_n && (state_q == BURST) && !bus.fifo_empty &&
            (issued_q < len_q) && (slots < SLOT_W'(2));
  end

  // State register and registered status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  // Burst counters, in-flight tracking and the ordered two-entry buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      if (start_acc) begin
        len_q    <= burst_len;
        issued_q <= '0;
        sent_q   <= '0;
      end else begin
        if (rd_en) issued_q <= issued_q + LEN_WIDTH'(1);
        if (pop && (sent_q != len_q)) sent_q <= sent_q + LEN_WIDTH'(1);
      end

      inflight_q <= rd_en;

      // buf0 always holds the oldest word so m_data stays put until popped.
      case ({inflight_q, pop})
        2'b10: begin
          if (occ_q == 2'd0) buf0_q <= bus.fifo_data_out;
          else               buf1_q <= bus.fifo_data_out;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          buf0_q <= buf1_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            buf0_q <= bus.fifo_data_out;
          end else begin
            buf0_q <= buf1_q;
            buf1_q <= bus.fifo_data_out;
          end
        end
        default: ;
      endcase

      // A fresh underflow wins over the clear from an accepted start.
      err_q <= bus.fifo_underflow | (err_q & ~start_acc);
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (occ_q != 2'd0);
  assign bus.m_data     = buf0_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign words_sent     = sent_q;
  assign err_underflow  = err_q;

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain with a one-cycle-latency FIFO model.
module tb_fifo_drain;
  localparam int unsigned DW = 16;
  localparam int unsigned LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic          busy, done, err;
  logic [LW-1:0] words_sent;

  fifo_drain_if #(.DATA_WIDTH(DW)) bus ();

  fifo_drain #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .burst_len     (burst_len),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .words_sent    (words_sent),
    .err_underflow (err)
  );

  always #5 clk = ~clk;

  // FIFO model
  logic [DW-1:0] mem [64];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          flush = 1'b0;
  logic          uf_reg = 1'b0;
  logic          force_uf = 1'b0;

  assign bus.fifo_empty     = (wr_ptr == rd_ptr);
  assign bus.fifo_underflow = uf_reg | force_uf;

  always @(posedge clk) begin
    uf_reg <= bus.fifo_rd_en && bus.fifo_empty;
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (bus.fifo_rd_en && !bus.fifo_empty) begin
      bus.fifo_data_out <= mem[rd_ptr % 64];
      rd_ptr <= rd_ptr + 1;
    end
  end

  int tests = 0;
  int fails = 0;

  // Results gathered by run_burst
  logic [DW-1:0] got[$];
  logic [DW-1:0] pend_q[$];
  int first_rd, first_valid, last_pop, done_cnt, done_cyc, rd_cnt;
  int rd_empty_bad, stable_bad, max_occ, timed_out;
  logic [LW-1:0] ws_at_done;
  logic pr_rd, pr_valid, pr_busy, pr_done, pr_err;
  logic [DW-1:0] pr_data;
  logic [LW-1:0] pr_ws;

  task automatic push(input logic [DW-1:0] d);
    mem[wr_ptr % 64] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  // Cycle 0 carries start; inputs are driven at negedge, outputs observed 1 unit later.
  task automatic run_burst(input logic [LW-1:0] len, input int ready_mode,
                           input int push_period, input int restart_cyc,
                           input int rst_cyc, input int max_cyc);
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    got.delete();
    first_rd = -1; first_valid = -1; last_pop = -1; done_cnt = 0; done_cyc = -1;
    rd_cnt = 0; rd_empty_bad = 0; stable_bad = 0; max_occ = 0; timed_out = 1;
    ws_at_done = '0;
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      start       = (k == 0) || (k == restart_cyc);
      burst_len   = (k == 0) ? len : LW'(len + 8'd3);
      rst_n       = (k != rst_cyc);
      bus.m_ready = (ready_mode == 0) ? 1'b1 : ((k % 2) == 0);
      if (push_period > 0 && (k % push_period) == 2 && pend_q.size() > 0)
        push(pend_q.pop_front());
      #1;
      if (bus.fifo_rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = k;
        if (bus.fifo_empty) rd_empty_bad++;
      end
      if (bus.m_valid && first_valid < 0) first_valid = k;
      if (prev_stall && bus.m_data !== prev_data) stable_bad++;
      prev_stall = bus.m_valid && !bus.m_ready && rst_n;
      prev_data  = bus.m_data;
      if (bus.m_valid && bus.m_ready && rst_n) begin
        got.push_back(bus.m_data);
        last_pop = k;
      end
      if (int'(dut.occ_q) > max_occ) max_occ = int'(dut.occ_q);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc   = k;
          ws_at_done = words_sent;
        end
      end
      if (k == rst_cyc + 1) begin
        pr_rd = bus.fifo_rd_en; pr_valid = bus.m_valid; pr_data = bus.m_data;
        pr_busy = busy; pr_done = done; pr_ws = words_sent; pr_err = err;
      end
      if (done_cnt > 0 && !busy) begin
        timed_out = 0;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; bus.m_ready = 1'b0; force_uf = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({bus.fifo_rd_en, bus.m_valid, busy, done, err} !== 5'b0) begin
      fails++; $display("FAIL reset_flags: got %b expected 00000", {bus.fifo_rd_en, bus.m_valid, busy, done, err});
    end
    tests++;
    if (bus.m_data !== 16'h0) begin
      fails++; $display("FAIL reset_m_data: got %h expected 0000", bus.m_data);
    end
    tests++;
    if (words_sent !== 8'd0) begin
      fails++; $display("FAIL reset_words_sent: got %0d expected 0", words_sent);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 5; i++) push(DW'(i));
    run_burst(8'd5, 0, 0, -1, -1, 40);
    tests++;
    if (timed_out !== 0) begin fails++; $display("FAIL basic_timeout: got %0d expected 0", timed_out); end
    tests++;
    if (got.size() !== 5) begin fails++; $display("FAIL basic_count: got %0d expected 5", got.size()); end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (i >= got.size() || got[i] !== DW'(i + 1)) begin
        fails++; $display("FAIL basic_word%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 16'hxxxx, DW'(i + 1));
      end
    end
    tests++;
    if (first_rd !== 1 || first_valid !== 3) begin
      fails++; $display("FAIL basic_latency: got rd %0d valid %0d expected rd 1 valid 3", first_rd, first_valid);
    end
    tests++;
    if (last_pop !== 7) begin fails++; $display("FAIL basic_last_pop: got %0d expected 7", last_pop); end
    tests++;
    if (done_cyc !== 9 || done_cnt !== 1) begin
      fails++; $display("FAIL basic_done: got cyc %0d cnt %0d expected cyc 9 cnt 1", done_cyc, done_cnt);
    end
    tests++;
    if (ws_at_done !== 8'd5 || words_sent !== 8'd5) begin
      fails++; $display("FAIL basic_words_sent: got %0d/%0d expected 5/5", ws_at_done, words_sent);
    end
  endtask

  task automatic test_toggle_ready();
    for (int i = 0; i < 4; i++) push(DW'(16'h11 + i));
    run_burst(8'd4, 1, 0, -1, -1, 60);
    tests++;
    if (timed_out !== 0 || got.size() !== 4) begin
      fails++; $display("FAIL toggle_count: got %0d words timeout %0d expected 4 words", got.size(), timed_out);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (i >= got.size() || got[i] !== DW'(16'h11 + i)) begin
        fails++; $display("FAIL toggle_word%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 16'hxxxx, DW'(16'h11 + i));
      end
    end
    tests++;
    if (stable_bad !== 0) begin fails++; $display("FAIL toggle_stable: got %0d changes expected 0", stable_bad); end
    tests++;
    if (max_occ > 2) begin fails++; $display("FAIL toggle_occupancy: got %0d expected <=2", max_occ); end
    tests++;
    if (done_cnt !== 1 || ws_at_done !== 8'd4) begin
      fails++; $display("FAIL toggle_done: got cnt %0d ws %0d expected cnt 1 ws 4", done_cnt, ws_at_done);
    end
  endtask

  task automatic test_slow_fifo();
    pend_q = '{16'h41, 16'h42, 16'h43};
    run_burst(8'd3, 0, 5, -1, -1, 60);
    tests++;
    if (rd_empty_bad !== 0) begin fails++; $display("FAIL slow_rd_on_empty: got %0d expected 0", rd_empty_bad); end
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL slow_err: got %b expected 0", err); end
    tests++;
    if (got.size() !== 3 || got[0] !== 16'h41 || got[1] !== 16'h42 || got[2] !== 16'h43) begin
      fails++; $display("FAIL slow_words: got %0d words expected 41 42 43", got.size());
    end
    tests++;
    if (last_pop !== 14 || done_cyc !== 16) begin
      fails++; $display("FAIL slow_done: got pop %0d done %0d expected pop 14 done 16", last_pop, done_cyc);
    end
  endtask

  task automatic test_zero_len();
    push(16'h55);
    run_burst(8'd0, 0, 0, -1, -1, 10);
    tests++;
    if (rd_cnt !== 0) begin fails++; $display("FAIL zero_reads: got %0d expected 0", rd_cnt); end
    tests++;
    if (done_cyc !== 1 || done_cnt !== 1) begin
      fails++; $display("FAIL zero_done: got cyc %0d cnt %0d expected cyc 1 cnt 1", done_cyc, done_cnt);
    end
    tests++;
    if (ws_at_done !== 8'd0) begin fails++; $display("FAIL zero_words_sent: got %0d expected 0", ws_at_done); end
    do_flush();
  endtask

  task automatic test_busy_restart();
    for (int i = 0; i < 4; i++) push(DW'(16'h21 + i));
    run_burst(8'd3, 0, 0, 2, -1, 40);
    tests++;
    if (got.size() !== 3 || got[0] !== 16'h21 || got[1] !== 16'h22 || got[2] !== 16'h23) begin
      fails++; $display("FAIL restart_words: got %0d words expected 21 22 23", got.size());
    end
    tests++;
    if (rd_cnt !== 3) begin fails++; $display("FAIL restart_reads: got %0d expected 3", rd_cnt); end
    tests++;
    if (done_cyc !== 7 || ws_at_done !== 8'd3 || done_cnt !== 1) begin
      fails++; $display("FAIL restart_done: got cyc %0d ws %0d cnt %0d expected 7 3 1", done_cyc, ws_at_done, done_cnt);
    end
    do_flush();
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 6; i++) push(DW'(16'h31 + i));
    run_burst(8'd5, 0, 0, -1, 5, 7);
    tests++;
    if (got.size() !== 2 || got[0] !== 16'h31 || got[1] !== 16'h32) begin
      fails++; $display("FAIL rst_pre_words: got %0d words expected 31 32", got.size());
    end
    tests++;
    if ({pr_rd, pr_valid, pr_busy, pr_done, pr_err} !== 5'b0 || pr_data !== 16'h0 || pr_ws !== 8'd0) begin
      fails++; $display("FAIL rst_outputs: got flags %b data %h ws %0d expected 00000 0000 0",
                        {pr_rd, pr_valid, pr_busy, pr_done, pr_err}, pr_data, pr_ws);
    end
    run_burst(8'd2, 0, 0, -1, -1, 30);
    tests++;
    if (got.size() !== 2 || got[0] !== 16'h35 || got[1] !== 16'h36) begin
      fails++; $display("FAIL rst_post_words: got %0d words first %h expected 35 36", got.size(), (got.size() > 0) ? got[0] : 16'hxxxx);
    end
    tests++;
    if (done_cyc !== 6 || ws_at_done !== 8'd2) begin
      fails++; $display("FAIL rst_post_done: got cyc %0d ws %0d expected 6 2", done_cyc, ws_at_done);
    end
  endtask

  task automatic test_underflow();
    @(negedge clk);
    force_uf = 1'b1;
    @(negedge clk);
    force_uf = 1'b0;
    #1;
    tests++;
    if (err !== 1'b1) begin fails++; $display("FAIL uf_set: got %b expected 1", err); end
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (err !== 1'b1) begin fails++; $display("FAIL uf_sticky: got %b expected 1", err); end
    run_burst(8'd0, 0, 0, -1, -1, 10);
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL uf_clear_on_start: got %b expected 0", err); end
  endtask

  initial begin
    bus.m_ready = 1'b0;
    test_reset();
    test_basic();
    test_toggle_ready();
    test_slow_fifo();
    test_zero_len();
    test_busy_restart();
    test_reset_mid_burst();
    test_underflow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 expected finish");
    $fatal(1);
  end

endmodule

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001: Parameter DATA_WIDTH, default 16, width of FIFO read data and output stream data.
REQ-002: Parameter LEN_WIDTH, default 8, width of burst length and word counter.
REQ-003: clk  input  1  single clock, all state updates on rising edge.
REQ-004: rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-005: start  input  1  burst request, accepted only in IDLE.
REQ-006: burst_len  input  LEN_WIDTH  number of words to drain, latched when start is accepted.
REQ-007: fifo_rd_en  output  1  read strobe to FIFO read port.
REQ-008: fifo_data_out  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en accepted.
REQ-009: fifo_empty  input  1  FIFO empty flag.
REQ-010: fifo_underflow  input  1  FIFO underflow flag.
REQ-011: m_valid  output  1  output stream word valid.
REQ-012: m_ready  input  1  downstream accepts word.
REQ-013: m_data  output  DATA_WIDTH  output stream word.
REQ-014: busy  output  1  high in BURST and DONE states.
REQ-015: done  output  1  one-cycle pulse at burst completion.
REQ-016: words_sent  output  LEN_WIDTH  words transferred on m_* in the current/last burst.
REQ-017: err_underflow  output  1  sticky, set when fifo_underflow seen high.

Function
REQ-018: FSM states IDLE, BURST, DONE; IDLE->BURST on start (burst_len != 0); IDLE->DONE on start with burst_len == 0; BURST->DONE when words_sent == latched length; DONE->IDLE after exactly one cycle.
REQ-019: start while not IDLE shall be ignored; burst_len changes after acceptance shall have no effect.
REQ-020: Accepted start shall clear words_sent, issued-read count and err_underflow.
REQ-021: FIFO read latency is one cycle: word for fifo_rd_en in cycle N is captured from fifo_data_out at end of cycle N+1; one in-flight bit tracks it.
REQ-022: Two-entry output buffer, FIFO-ordered; m_valid = buffer non-empty; m_data = oldest entry.
REQ-023: pop = m_valid && m_ready; fifo_rd_en = BURST && !fifo_empty && issued < length && (occupancy + inflight - pop) < 2.
REQ-024: fifo_rd_en shall never assert while fifo_empty is high (block never causes underflow).
REQ-025: Simultaneous capture and pop in one cycle shall keep occupancy unchanged and preserve order.
REQ-026: m_valid, once high, shall hold with stable m_data until pop.
REQ-027: words_sent increments by 1 per pop, never exceeds latched length; no wrap within a burst.
REQ-028: With fifo_empty low and m_ready held high, steady state shall be one word per cycle; first m_valid exactly 2 cycles after first fifo_rd_en.
REQ-029: done asserts only in DONE state; busy low only in IDLE.
REQ-030: fifo_underflow high in any cycle shall set err_underflow next cycle; it holds until reset or accepted start.

Reset
REQ-031: rst_n low at a rising edge shall force IDLE, fifo_rd_en=0, m_valid=0, m_data=0, busy=0, done=0, words_sent=0, err_underflow=0, buffer and in-flight cleared.
REQ-032: Reset mid-burst shall discard buffered and in-flight words; no m_valid in the cycle after reset deasserts.

Verification
REQ-033: FIFO preloaded 0x0001..0x0005, m_ready=1, start with burst_len=5 -> m_data 0x0001..0x0005 on consecutive cycles, words_sent=5, done one-cycle pulse, busy returns low.
REQ-034: burst_len=4, m_ready toggling 1/0 each cycle -> no dropped/duplicated words, m_data stable while m_valid && !m_ready, occupancy never exceeds 2.
REQ-035: burst_len=3, FIFO empty initially, one word written every 5 cycles -> fifo_rd_en never high with fifo_empty high, err_underflow stays 0, done after third pop.
REQ-036: start with burst_len=0 -> no fifo_rd_en, done pulse exactly one cycle later, words_sent=0.
REQ-037: rst_n driven low for one cycle mid-burst after 2 pops -> all outputs at reset values next cycle, subsequent start with burst_len=2 delivers next 2 FIFO words in order.
REQ-038: start pulsed again while busy -> ignored; latched length and words_sent unaffected.
